gray_to_binary_tracker: RTL and testbench

GRAY_TO_BINARY_TRACKER -- requirements
Module: gray_to_binary_tracker

---
 rtl/gray_to_binary_tracker_pkg.sv | 12 +
 rtl/gray2binary.sv | 17 +
 rtl/gray_to_binary_tracker.sv | 104 ++++++++++
 tb/tb_gray_to_binary_tracker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/gray_to_binary_tracker_pkg.sv
// Shared widths and tracker state encoding for the Gray-to-binary tracker.
package gray_to_binary_tracker_pkg;

  localparam int unsigned TRK_WIDTH = 12;
  localparam int unsigned TRK_ERR_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

endpackage

// File: rtl/gray2binary.sv
// Combinational Gray-to-binary decode, the inverse of Binary2Gray.
module gray2binary #(
  parameter int unsigned WIDTH = 12
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // bin[i] = XOR of gray[WIDTH-1:i], the unrolled form of the MSB-down chain
  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_to_binary_tracker.sv
// Two-stage Gray decoder that tracks direction and counts illegal multi-bit steps.
module gray_to_binary_tracker
  import gray_to_binary_tracker_pkg::*;
#(
  parameter int unsigned WIDTH = TRK_WIDTH,
  parameter int unsigned ERR_W = TRK_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr_err,
  output logic             out_vld,
  output logic [WIDTH-1:0] bin_out,
  output logic             dir,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt
);

  state_t           state, state_nx;
  logic             s1_vld;
  logic [WIDTH-1:0] s1_gray;
  logic [WIDTH-1:0] ref_gray;
  logic [WIDTH-1:0] dec_bin;
  logic [WIDTH-1:0] diff;
  logic             one_bit;
  logic             dir_nx;
  logic             step_err_nx;
  logic             err_inc;
  logic [ERR_W-1:0] err_nx;

  gray2binary #(.WIDTH(WIDTH)) u_dec (
    .gray (s1_gray),
    .bin  (dec_bin)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_gray <= '0;
    end else begin
      s1_vld  <= in_vld;
      s1_gray <= gray_in;
    end
  end

  assign diff    = s1_gray ^ ref_gray;
  assign one_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

  // bin_out always equals the binary reference, so it doubles as ref_bin
  always_comb begin
    state_nx    = state;
    dir_nx      = dir;
    step_err_nx = 1'b0;
    err_inc     = 1'b0;
    if (s1_vld) begin
      state_nx = TRACK;
      case (state)
        IDLE: ;
        TRACK: begin
          if (one_bit) begin
            dir_nx = (dec_bin == bin_out + WIDTH'(1));
          end else if (diff != '0) begin
            step_err_nx = 1'b1;
            err_inc     = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    err_nx = err_cnt;
    if (clr_err) begin
      err_nx = '0;
    end else if (err_inc && (err_cnt != '1)) begin
      err_nx = err_cnt + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      out_vld  <= 1'b0;
      bin_out  <= '0;
      ref_gray <= '0;
      dir      <= 1'b1;
      step_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nx;
      out_vld  <= s1_vld;
      step_err <= step_err_nx;
      dir      <= dir_nx;
      err_cnt  <= err_nx;
      if (s1_vld) begin
        bin_out  <= dec_bin;
        ref_gray <= s1_gray;
      end
    end
  end

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Directed self-checking bench for gray_to_binary_tracker.
module tb_gray_to_binary_tracker;

  logic        clk;
  logic        rst_n;
  logic        in_vld;
  logic [11:0] gray_in;
  logic        clr_err;
  logic        out_vld;
  logic [11:0] bin_out;
  logic        dir;
  logic        step_err;
  logic [7:0]  err_cnt;

  int errors;
  int checks;

  gray_to_binary_tracker #(.WIDTH(12), .ERR_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .gray_in  (gray_in),
    .clr_err  (clr_err),
    .out_vld  (out_vld),
    .bin_out  (bin_out),
    .dir      (dir),
    .step_err (step_err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] bin2gray(input logic [11:0] b);
    return b ^ (b >> 1);
  endfunction

  // Present inputs for one clock; outputs sampled afterwards reflect the previous step's sample.
  task automatic step(input logic v, input logic [11:0] g, input logic c);
    in_vld  = v;
    gray_in = g;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 12'h000, 1'b0);
    step(1'b0, 12'h000, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 12'h5A5, 1'b0);
    step(1'b1, 12'h3C3, 1'b0);
    step(1'b0, 12'h000, 1'b0);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
    checks++; if (bin_out !== 12'h000) begin errors++; $display("FAIL reset_bin_out got=%h exp=000", bin_out); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL reset_dir got=%b exp=1", dir); end
    checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL reset_step_err got=%b exp=0", step_err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_up_count();
    logic [11:0] exp_bin;
    step(1'b0, 12'h000, 1'b0);
    for (int n = 0; n <= 4096; n++) begin
      step(1'b1, bin2gray(12'(n % 4096)), 1'b0);
      if (n > 0) begin
        exp_bin = 12'((n - 1) % 4096);
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL up_vld n=%0d got=%b exp=1", n, out_vld); end
        checks++; if (bin_out !== exp_bin) begin errors++; $display("FAIL up_bin n=%0d got=%h exp=%h", n, bin_out, exp_bin); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL up_dir n=%0d got=%b exp=1", n, dir); end
        checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL up_step_err n=%0d got=%b exp=0", n, step_err); end
      end
    end
    step(1'b0, 12'h000, 1'b0);
    checks++; if (bin_out !== 12'h000) begin errors++; $display("FAIL up_wrap_bin got=%h exp=000", bin_out); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL up_wrap_dir got=%b exp=1", dir); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL up_err_cnt got=%0d exp=0", err_cnt); end
    step(1'b0, 12'h000, 1'b0);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL up_idle_vld got=%b exp=0", out_vld); end
  endtask

  task automatic test_down_wrap();
    logic [11:0] seq  [9] = '{12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1, 12'd0, 12'd4095, 12'd0};
    logic        edir [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) step(1'b1, bin2gray(seq[i]), 1'b0);
      else       step(1'b0, 12'h000, 1'b0);
      if (i > 0) begin
        checks++; if (bin_out !== seq[i-1]) begin errors++; $display("FAIL down_bin i=%0d got=%h exp=%h", i, bin_out, seq[i-1]); end
        checks++; if (dir !== edir[i-1]) begin errors++; $display("FAIL down_dir i=%0d got=%b exp=%b", i, dir, edir[i-1]); end
        checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL down_step_err i=%0d got=%b exp=0", i, step_err); end
      end
    end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL down_err_cnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_illegal_step();
    do_reset();
    step(1'b1, 12'h000, 1'b0);
    step(1'b1, 12'h003, 1'b0);
    checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL ill_first_step_err got=%b exp=0", step_err); end
    step(1'b0, 12'h000, 1'b0);
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL ill_vld got=%b exp=1", out_vld); end
    checks++; if (step_err !== 1'b1) begin errors++; $display("FAIL ill_step_err got=%b exp=1", step_err); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL ill_err_cnt got=%0d exp=1", err_cnt); end
    checks++; if (bin_out !== 12'h002) begin errors++; $display("FAIL ill_bin got=%h exp=002", bin_out); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL ill_dir got=%b exp=1", dir); end
    step(1'b0, 12'h000, 1'b0);
    checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL ill_pulse_len got=%b exp=0", step_err); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL ill_err_hold got=%0d exp=1", err_cnt); end
    checks++; if (bin_out !== 12'h002) begin errors++; $display("FAIL ill_bin_hold got=%h exp=002", bin_out); end
  endtask

  task automatic test_saturate_clear();
    int exp_cnt;
    do_reset();
    for (int i = 0; i <= 300; i++) begin
      step(1'b1, (i % 2 == 1) ? 12'h003 : 12'h000, 1'b0);
      exp_cnt = (i >= 2) ? ((i - 1 > 255) ? 255 : i - 1) : 0;
      checks++; if (err_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL sat_err_cnt i=%0d got=%0d exp=%0d", i, err_cnt, exp_cnt); end
      checks++; if (step_err !== (i >= 2)) begin errors++; $display("FAIL sat_step_err i=%0d got=%b exp=%b", i, step_err, (i >= 2)); end
    end
    step(1'b1, 12'h003, 1'b1);
    checks++; if (step_err !== 1'b1) begin errors++; $display("FAIL clr_step_err got=%b exp=1", step_err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL clr_err_cnt got=%0d exp=0", err_cnt); end
    step(1'b0, 12'h000, 1'b0);
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL clr_after_inc got=%0d exp=1", err_cnt); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    step(1'b1, 12'h000, 1'b0);
    step(1'b1, 12'h001, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 12'h003, 1'b0);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_vld got=%b exp=0", out_vld); end
    rst_n = 1'b1;
    step(1'b0, 12'h000, 1'b0);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL mid_flush1_vld got=%b exp=0", out_vld); end
    step(1'b1, 12'hFFF, 1'b0);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL mid_flush2_vld got=%b exp=0", out_vld); end
    step(1'b0, 12'h000, 1'b0);
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL mid_new_vld got=%b exp=1", out_vld); end
    checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL mid_new_step_err got=%b exp=0", step_err); end
    checks++; if (bin_out !== 12'hAAA) begin errors++; $display("FAIL mid_new_bin got=%h exp=AAA", bin_out); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL mid_err_cnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_vld_toggle();
    logic        v    [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [11:0] g    [6] = '{12'h003, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001};
    logic        evld [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [11:0] ebin [6] = '{12'h000, 12'h002, 12'h001, 12'h001, 12'h001, 12'h001};
    logic        edir [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(v[i], g[i], 1'b0);
      checks++; if (out_vld !== evld[i]) begin errors++; $display("FAIL tog_vld i=%0d got=%b exp=%b", i, out_vld, evld[i]); end
      checks++; if (bin_out !== ebin[i]) begin errors++; $display("FAIL tog_bin i=%0d got=%h exp=%h", i, bin_out, ebin[i]); end
      checks++; if (dir !== edir[i]) begin errors++; $display("FAIL tog_dir i=%0d got=%b exp=%b", i, dir, edir[i]); end
      checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL tog_step_err i=%0d got=%b exp=0", i, step_err); end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    gray_in = '0;
    clr_err = 1'b0;
    test_reset();
    test_up_count();
    test_down_wrap();
    test_illegal_step();
    test_saturate_clear();
    test_reset_midstream();
    test_vld_toggle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
